// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised modulo up/down counter with clear, load, wrap pulses and boundary flags; define UDC_SAT_EN to add runtime-selectable saturation
module updown_counter_mod #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              up,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
`ifdef UDC_SAT_EN
  input  logic              sat_mode,
  output logic              sat_flag,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              wrap_up,
  output logic              wrap_down,
  output logic              at_max,
  output logic              at_min
);
  localparam logic [WIDTH:0] MX = {1'b0, MAX_VAL};
  localparam logic [WIDTH-1:0] MODL = MAX_VAL + {{(WIDTH-1){1'b0}}, 1'b1};
  logic [WIDTH:0] st, s, cur, sum;
  logic [WIDTH-1:0] sl, lv, up_n, dn_n, count_d;
  logic ovf, unf, inc, dec, sat, wu_d, wd_d;
`ifdef UDC_SAT_EN
  logic sat_set;
  assign sat = sat_mode;
  assign sat_set = ~clear & ~load & sat & ((inc & ovf) | (dec & unf));
`else
  assign sat = 1'b0;
`endif
  // next-state: comparisons done in WIDTH+1 bits, results reduced modulo MAX_VAL+1
  always_comb begin
    st = {{(WIDTH+1-STEP_W){1'b0}}, step};
    s = st > MX ? MX : st;
    sl = s[WIDTH-1:0];
    cur = {1'b0, count};
    sum = cur + s;
    ovf = sum > MX;
    unf = cur < s;
    inc = up & ~down & |s;
    dec = down & ~up & |s;
    lv = load_val > MAX_VAL ? MAX_VAL : load_val;
    up_n = count + sl - (ovf ? MODL : '0);
    dn_n = count - sl + (unf ? MODL : '0);
    count_d = clear ? '0 : load ? lv : inc ? ((ovf & sat) ? MAX_VAL : up_n) : dec ? ((unf & sat) ? '0 : dn_n) : count;
    wu_d = ~clear & ~load & inc & ovf & ~sat;
    wd_d = ~clear & ~load & dec & unf & ~sat;
  end
  // count and single-cycle wrap pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      wrap_up <= 1'b0;
      wrap_down <= 1'b0;
    end else begin
      count <= count_d;
      wrap_up <= wu_d;
      wrap_down <= wd_d;
    end
  end
`ifdef UDC_SAT_EN
  // sticky saturation indicator, cleared only by clear or reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sat_flag <= 1'b0;
    else if (clear) sat_flag <= 1'b0;
    else if (sat_set) sat_flag <= 1'b1;
  end
`endif
  assign at_max = count == MAX_VAL;
  assign at_min = count == '0;
endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: directed and randomized checks of updown_counter_mod against an integer reference model
module tb_updown_counter_mod;
  localparam int MAXV = 9;
  logic clk = 0, reset_n = 0;
  logic clear = 0, load = 0, up = 0, down = 0, sat_mode = 0;
  logic [7:0] load_val = 0;
  logic [3:0] step = 0;
  logic [7:0] count;
  logic wrap_up, wrap_down, at_max, at_min, sat_flag;
  logic b_clear = 0, b_up = 0;
  logic [3:0] b_count;
  logic b_wu, b_wd, b_max, b_min, b_sf;
  int checks = 0, failures = 0;
  int m_c = 0;
  bit m_wu = 0, m_wd = 0, m_sf = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(8), .MAX_VAL(8'd9), .STEP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_val(load_val),
    .up(up), .down(down), .step(step),
`ifdef UDC_SAT_EN
    .sat_mode(sat_mode), .sat_flag(sat_flag),
`endif
    .count(count), .wrap_up(wrap_up), .wrap_down(wrap_down), .at_max(at_max), .at_min(at_min));

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(4'd15), .STEP_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(b_clear), .load(1'b0), .load_val(4'd0),
    .up(b_up), .down(1'b0), .step(4'd1),
`ifdef UDC_SAT_EN
    .sat_mode(1'b0), .sat_flag(b_sf),
`endif
    .count(b_count), .wrap_up(b_wu), .wrap_down(b_wd), .at_max(b_max), .at_min(b_min));

`ifndef UDC_SAT_EN
  assign sat_flag = 1'b0;
  assign b_sf = 1'b0;
`endif

  task automatic model_update(input bit cl, ld, input int lv, input bit u, d, input int st, input bit sm);
    int s, n;
    bit se;
    se = 0;
`ifdef UDC_SAT_EN
    se = sm;
`endif
    m_wu = 0;
    m_wd = 0;
    s = st > MAXV ? MAXV : st;
    if (cl) begin
      m_c = 0;
      m_sf = 0;
    end else if (ld) m_c = lv > MAXV ? MAXV : lv;
    else if (u && !d && s > 0) begin
      n = m_c + s;
      if (n > MAXV) begin
        if (se) begin m_c = MAXV; m_sf = 1; end
        else begin m_c = n - (MAXV + 1); m_wu = 1; end
      end else m_c = n;
    end else if (d && !u && s > 0) begin
      n = m_c - s;
      if (n < 0) begin
        if (se) begin m_c = 0; m_sf = 1; end
        else begin m_c = n + (MAXV + 1); m_wd = 1; end
      end else m_c = n;
    end
  endtask

  task automatic apply(input bit cl, ld, input int lv, input bit u, d, input int st, input bit sm);
    clear = cl; load = ld; load_val = lv[7:0]; up = u; down = d; step = st[3:0]; sat_mode = sm;
    @(posedge clk);
    #1;
    model_update(cl, ld, lv & 255, u, d, st & 15, sm);
    clear = 0; load = 0; up = 0; down = 0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({count, wrap_up, wrap_down, at_max, at_min, sat_flag} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state count=%0d wu=%b wd=%b max=%b min=%b sf=%b want count=0 min=1", count, wrap_up, wrap_down, at_max, at_min, sat_flag);
    end
    reset_n = 1;
    apply(0, 1, 5, 0, 0, 0, 0);
    checks++;
    if (count !== 8'd5) begin failures++; $display("FAIL load5 count=%0d want=5", count); end
    #2 reset_n = 0;
    #1;
    checks++;
    if (count !== 8'd0 || at_min !== 1'b1 || at_max !== 1'b0) begin
      failures++;
      $display("FAIL async_reset count=%0d min=%b max=%b want count=0 min=1 max=0", count, at_min, at_max);
    end
    m_c = 0; m_wu = 0; m_wd = 0; m_sf = 0;
    #1 reset_n = 1;
  endtask

  task automatic test_wrap;
    apply(0, 1, 8, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 3, 0);
    checks++;
    if (count !== 8'd1 || wrap_up !== 1'b1 || wrap_down !== 1'b0) begin
      failures++; $display("FAIL wrap_up count=%0d wu=%b wd=%b want 1,1,0", count, wrap_up, wrap_down);
    end
    apply(0, 0, 0, 0, 0, 3, 0);
    checks++;
    if (count !== 8'd1 || wrap_up !== 1'b0) begin
      failures++; $display("FAIL wrap_up_pulse_end count=%0d wu=%b want 1,0", count, wrap_up);
    end
    apply(0, 0, 0, 0, 1, 3, 0);
    checks++;
    if (count !== 8'd8 || wrap_down !== 1'b1 || wrap_up !== 1'b0) begin
      failures++; $display("FAIL wrap_down count=%0d wd=%b wu=%b want 8,1,0", count, wrap_down, wrap_up);
    end
  endtask

  task automatic test_priority;
    apply(0, 1, 4, 0, 0, 0, 0);
    apply(1, 1, 7, 1, 0, 1, 0);
    checks++;
    if (count !== 8'd0 || at_min !== 1'b1) begin
      failures++; $display("FAIL prio_clear count=%0d min=%b want 0,1", count, at_min);
    end
    apply(0, 1, 12, 1, 0, 1, 0);
    checks++;
    if (count !== 8'd9 || at_max !== 1'b1) begin
      failures++; $display("FAIL prio_load_clamp count=%0d max=%b want 9,1", count, at_max);
    end
    apply(0, 0, 0, 1, 1, 3, 0);
    checks++;
    if (count !== 8'd9 || wrap_up !== 1'b0 || wrap_down !== 1'b0) begin
      failures++; $display("FAIL prio_both_dirs count=%0d wu=%b wd=%b want 9,0,0", count, wrap_up, wrap_down);
    end
  endtask

  task automatic test_step_clamp;
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 15, 0);
    checks++;
    if (count !== 8'd9 || wrap_up !== 1'b0) begin
      failures++; $display("FAIL step_clamp count=%0d wu=%b want 9,0", count, wrap_up);
    end
    apply(0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (count !== 8'd9 || wrap_up !== 1'b0 || wrap_down !== 1'b0) begin
      failures++; $display("FAIL step_zero count=%0d wu=%b wd=%b want 9,0,0", count, wrap_up, wrap_down);
    end
  endtask

`ifdef UDC_SAT_EN
  task automatic test_saturate;
    apply(0, 1, 8, 0, 0, 0, 1);
    apply(0, 0, 0, 1, 0, 4, 1);
    checks++;
    if (count !== 8'd9 || sat_flag !== 1'b1 || wrap_up !== 1'b0) begin
      failures++; $display("FAIL sat_up count=%0d sf=%b wu=%b want 9,1,0", count, sat_flag, wrap_up);
    end
    apply(0, 0, 0, 0, 1, 2, 1);
    checks++;
    if (count !== 8'd7 || sat_flag !== 1'b1) begin
      failures++; $display("FAIL sat_sticky count=%0d sf=%b want 7,1", count, sat_flag);
    end
    apply(1, 0, 0, 0, 0, 0, 1);
    checks++;
    if (count !== 8'd0 || sat_flag !== 1'b0) begin
      failures++; $display("FAIL sat_clear count=%0d sf=%b want 0,0", count, sat_flag);
    end
  endtask
`endif

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
      checks++;
      if ({count, wrap_up, wrap_down, at_max, at_min, sat_flag} !==
          {m_c[7:0], m_wu, m_wd, m_c == MAXV, m_c == 0, m_sf}) begin
        failures++;
        $display("FAIL random_%0d count=%0d wu=%b wd=%b max=%b min=%b sf=%b want count=%0d wu=%b wd=%b sf=%b",
                 i, count, wrap_up, wrap_down, at_max, at_min, sat_flag, m_c, m_wu, m_wd, m_sf);
      end
    end
  endtask

  task automatic test_free_run;
    int pulses;
    pulses = 0;
    b_clear = 1;
    @(posedge clk);
    #1 b_clear = 0;
    b_up = 1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      pulses += b_wu;
      checks++;
      if (b_count !== 4'(i % 16) || b_wu !== (i % 16 == 0) || b_wd !== 1'b0) begin
        failures++;
        $display("FAIL free_run_%0d count=%0d wu=%b wd=%b want count=%0d wu=%b", i, b_count, b_wu, b_wd, i % 16, i % 16 == 0);
      end
    end
    b_up = 0;
    checks++;
    if (pulses !== 2) begin failures++; $display("FAIL free_run_pulses got=%0d want=2", pulses); end
  endtask

  initial begin
    test_reset;
    test_wrap;
    test_priority;
    test_step_clamp;
`ifdef UDC_SAT_EN
    test_saturate;
`endif
    test_random;
    test_free_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
